// File: rtl/clk_div_gen.sv
// Multi-channel divided-waveform generator: per-channel programmable integer divisor,
// period-end tick, shadowed divisor updates applied at period boundaries, global realign.
module clk_div_gen #(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = 8,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DIV_W-1:0]  wr_div,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_pend
);

   logic [DIV_W-1:0]  div_act   [NUM_CH];
   logic [DIV_W-1:0]  div_shd   [NUM_CH];
   logic [DIV_W-1:0]  cnt       [NUM_CH];
   logic [DIV_W-1:0]  div_act_n [NUM_CH];
   logic [DIV_W-1:0]  div_shd_n [NUM_CH];
   logic [DIV_W-1:0]  cnt_n     [NUM_CH];
   logic [DIV_W-1:0]  settle    [NUM_CH];
   logic [NUM_CH-1:0] run, run_n, pend_n, clk_n, tick_n, hit, bnd;
   logic [DIV_W-1:0]  wr_val;

   // Reset divisor 2^(i+1), clamped to the largest legal divisor.
   function automatic logic [DIV_W-1:0] rst_div(input int i);
      logic [DIV_W-1:0] one;
      one = 1;
      if (i + 1 >= DIV_W) return '1;
      return one << (i + 1);
   endfunction

   // Number of high cycles: ceil(d/2), computed one bit wider to avoid overflow.
   function automatic logic [DIV_W-1:0] half_div(input logic [DIV_W-1:0] d);
      logic [DIV_W:0] t;
      t = {1'b0, d} + {{DIV_W{1'b0}}, 1'b1};
      return t[DIV_W:1];
   endfunction

   assign wr_val = (wr_div == '0) ? DIV_W'(1) : wr_div;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]    = wr_en && (wr_ch == CH_W'(i));
         settle[i] = div_pend[i] ? div_shd[i] : div_act[i];
      end
   end

   // A boundary (stop, start, realign or wrap) is where a divisor may take effect.
   always_comb begin
      bnd    = '0;
      run_n  = run;
      pend_n = div_pend;
      clk_n  = '0;
      tick_n = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bnd[i]       = !ch_en[i] || !run[i] || sync || (cnt[i] == div_act[i] - DIV_W'(1));
         cnt_n[i]     = cnt[i] + DIV_W'(1);
         div_act_n[i] = div_act[i];
         div_shd_n[i] = hit[i] ? wr_val : div_shd[i];
         if (bnd[i]) begin
            div_act_n[i] = hit[i] ? wr_val : settle[i];
            pend_n[i]    = 1'b0;
            cnt_n[i]     = '0;
            run_n[i]     = ch_en[i];
         end else if (hit[i]) begin
            pend_n[i] = 1'b1;
         end
         if (run_n[i]) begin
            clk_n[i]  = cnt_n[i] < half_div(div_act_n[i]);
            tick_n[i] = cnt_n[i] == div_act_n[i] - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run      <= '0;
         div_pend <= '0;
         clk_out  <= '0;
         tick     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_act[i] <= rst_div(i);
            div_shd[i] <= rst_div(i);
            cnt[i]     <= '0;
         end
      end else begin
         run      <= run_n;
         div_pend <= pend_n;
         clk_out  <= clk_n;
         tick     <= tick_n;
         for (int i = 0; i < NUM_CH; i++) begin
            div_act[i] <= div_act_n[i];
            div_shd[i] <= div_shd_n[i];
            cnt[i]     <= cnt_n[i];
         end
      end
   end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable/divided-clock generator. Derives NUM_CH independent divided waveforms from one fast clock, each with a run-time programmable integer divisor, a per-cycle period-end tick and a global phase-realign input. Used wherever a block needs slower, phase-related rates (e.g. 100/50/25 MHz-style families) from a single clock domain. Outputs are registered data signals, not clock-tree clocks.

## Interface
- NUM_CH, 3, number of channels (>=1)
- DIV_W, 8, divisor width; legal divisors 1..2^DIV_W-1
- CH_W, $clog2(NUM_CH) (min 1), channel-select width (derived)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- ch_en  in  NUM_CH  per-channel run enable
- wr_en  in  1  divisor write strobe
- wr_ch  in  CH_W  channel addressed by write
- wr_div  in  DIV_W  new divisor value
- sync  in  1  global realign strobe
- clk_out  out  NUM_CH  divided waveform per channel
- tick  out  NUM_CH  one-cycle pulse in last cycle of each period
- div_pend  out  NUM_CH  written divisor waiting for period boundary

## Operation
- Per channel: active divisor D, shadow divisor S, pending flag P, counter cnt (0..D-1), running flag.
- Reset values: D = S = min(2^(i+1), 2^DIV_W-1) for channel i (ch0=2, ch1=4, ch2=8); cnt=0; P=0; clk_out=0; tick=0; running=0.
- Waveform while running: in the cycle where cnt=k, clk_out = (k < ceil(D/2)), tick = (k == D-1). Even D: 50% duty; odd D: high one cycle longer than low.
- D=1: clk_out constant 1, tick 1 every cycle.
- wr_div=0 is stored as 1. wr_en with wr_ch >= NUM_CH ignored (no state change).
- Write to running channel: S <- value, P <- 1; applied at next wrap (cnt=D-1 edge): D <- S, P <- 0, cnt <- 0. Second write before wrap overwrites S; last value wins.
- Write to stopped channel: D and S updated directly, P stays 0.
- ch_en low: channel stops at next edge; cnt <- 0, clk_out <- 0, tick <- 0, any pending S applied to D, P <- 0.
- ch_en rising (sampled at edge E): after E cnt=0, clk_out=1, tick=(D==1).
- sync=1 at an edge: every enabled channel cnt <- 0, pending S applied (D <- S, P <- 0), clk_out <- 1. Stopped channels unaffected. sync has priority over normal wrap/increment.
- Write and sync at same edge on a running channel: written value becomes D immediately, P=0.
- Write and wrap at same edge: written value becomes D at that wrap, P=0.
- ch_en low and sync at same edge: channel stops (disable wins).

## Timing
- All outputs registered; clk_out/tick/div_pend change only on rising clk or asynchronously on reset assertion.
- Enable/sync/write latency: 1 cycle (visible after the sampling edge).
- Divisor change never truncates a period: the old period completes, the new one starts at cnt=0 on the following cycle.
- Reset asserted mid-operation: all outputs drop to reset values immediately, independent of clk; release takes effect at next rising edge; channels stay stopped until ch_en sampled high.
- Channels enabled at the same edge (or realigned by sync) share phase: all clk_out rise together and ticks of divisor multiples coincide.

## Test plan
- Reset, then ch_en=3'b111 at one edge -> ch0 period 2 (1 high/1 low), ch1 period 4 (2/2), ch2 period 8 (4/4); all rise at same edge; tick ch2 every 8th cycle coinciding with ch1 and ch0 ticks.
- Write ch0 div=5 while stopped, enable -> clk_out high 3 cycles, low 2; tick in 5th cycle; wr_div=0 then 1 -> clk_out stuck 1, tick every cycle.
- Running ch1 (D=4) at cnt=1, write 6 -> div_pend=1 for 2 more cycles, period of 4 completes, next period 6 (3/3), div_pend=0; back-to-back writes 6 then 10 -> 10 applied.
- Channels with D=4 and D=6 drifting, pulse sync -> both clk_out=1 and cnt=0 next cycle; pending divisor applied at sync; stopped channel stays 0.
- wr_ch=3 with NUM_CH=3 -> no change on any output; ch_en dropped with sync same edge -> channel stops.
- Assert rst asynchronously mid-period -> clk_out, tick, div_pend all 0 without a clock edge; after release and enable, divisors back to 2/4/8.
